// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
//   Tic-tac-toe game engine for a 3x3 board drawn by an external VGA path.
//   Buttons are edge detected and move a cursor or place a mark; after every
//   placement a one-cycle CHECK state scores the board for the player who
//   just moved. All outputs are registered.
//
//   Cell index k = row*3 + col (k=0 top-left, k=8 bottom-right).
//
// Ports
//   clk                     system clock (shared with the VGA path)
//   reset                   asynchronous, active-low reset
//   btn_up/down/left/right  debounced level buttons, cursor movement
//   btn_place               debounced level button, place mark / restart
//   cells[17:0]             per cell: [2k] draw enable, [2k+1] shape/owner
//   color[8:0]              per cell highlight (1 = red, 0 = white)
//   turn                    player to move
//   state[1:0]              0 PLAY, 1 CHECK, 2 WIN, 3 DRAW
//   winner                  winning player, valid in WIN only
//
// Build option
//   CURSOR_BLINK_EN         when defined, the cursor preview blinks using a
//                           free-running BLINK_W-bit counter; otherwise the
//                           preview is always on and no counter exists.
// -----------------------------------------------------------------------------
module game_controller #(
    parameter int BLINK_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    output logic [17:0] cells,
    output logic [8:0]  color,
    output logic        turn,
    output logic [1:0]  state,
    output logic        winner
);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_CHECK = 2'd1,
        S_WIN   = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    // The 8 winning lines as cell masks: 3 rows, 3 columns, 2 diagonals.
    localparam logic [8:0] LINES [8] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    state_t      st;
    logic [8:0]  occ;          // cell occupied
    logic [8:0]  own;          // owner of an occupied cell
    logic [8:0]  win_mask;
    logic [3:0]  move_cnt;
    logic [1:0]  cur_row;
    logic [1:0]  cur_col;
    logic [3:0]  cur_idx;
    logic        turn_q;
    logic        winner_q;
    logic [4:0]  btn_now;
    logic [4:0]  btn_prev;
    logic [4:0]  btn_rise;
    logic [8:0]  mine;
    logic [8:0]  line_mask;
    logic        preview_on;
    logic [17:0] cells_d;
    logic [8:0]  color_d;

    // Bit order sets the action priority: place, up, down, left, right.
    assign btn_now  = {btn_place, btn_up, btn_down, btn_left, btn_right};
    assign btn_rise = btn_now & ~btn_prev;
    assign cur_idx  = {2'b00, cur_row} * 4'd3 + {2'b00, cur_col};

    // Cells held by the player who just moved (the player still in turn_q).
    assign mine = occ & (turn_q ? own : ~own);

`ifdef CURSOR_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) blink_cnt <= '0;
        else        blink_cnt <= blink_cnt + 1'b1;
    end

    assign preview_on = blink_cnt[BLINK_W-1];
`else
    // Always true for any legal width: the preview is steadily on.
    assign preview_on = (BLINK_W > 0);
`endif

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        line_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if ((mine & LINES[i]) == LINES[i]) line_mask = line_mask | LINES[i];
        end
    end

    always_comb begin
        cells_d = '0;
        color_d = '0;
        for (int k = 0; k < 9; k++) begin
            if (occ[k]) begin
                cells_d[2*k]   = 1'b1;
                cells_d[2*k+1] = own[k];
                color_d[k]     = (st == S_PLAY || st == S_CHECK) && (4'(k) == cur_idx);
            end else if (st == S_PLAY && 4'(k) == cur_idx) begin
                cells_d[2*k]   = preview_on;
                cells_d[2*k+1] = turn_q;
                color_d[k]     = 1'b1;
            end
        end
        if (st == S_WIN)       color_d = win_mask;
        else if (st == S_DRAW) color_d = '0;
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= S_PLAY;
            occ      <= '0;
            own      <= '0;
            win_mask <= '0;
            move_cnt <= '0;
            cur_row  <= 2'd1;
            cur_col  <= 2'd1;
            turn_q   <= 1'b0;
            winner_q <= 1'b0;
            // Held buttons must not register as an edge after reset.
            btn_prev <= '1;
            cells    <= '0;
            color    <= '0;
            turn     <= 1'b0;
            state    <= 2'd0;
            winner   <= 1'b0;
        end else begin
            btn_prev <= btn_now;

            unique case (st)
                S_PLAY: begin
                    if (btn_rise[4]) begin
                        if (!occ[cur_idx]) begin
                            occ[cur_idx] <= 1'b1;
                            own[cur_idx] <= turn_q;
                            move_cnt     <= move_cnt + 4'd1;
                            st           <= S_CHECK;
                        end
                    end else if (btn_rise[3]) begin
                        cur_row <= (cur_row == 2'd0) ? 2'd2 : cur_row - 2'd1;
                    end else if (btn_rise[2]) begin
                        cur_row <= (cur_row == 2'd2) ? 2'd0 : cur_row + 2'd1;
                    end else if (btn_rise[1]) begin
                        cur_col <= (cur_col == 2'd0) ? 2'd2 : cur_col - 2'd1;
                    end else if (btn_rise[0]) begin
                        cur_col <= (cur_col == 2'd2) ? 2'd0 : cur_col + 2'd1;
                    end
                end
                S_CHECK: begin
                    if (line_mask != '0) begin
                        st       <= S_WIN;
                        winner_q <= turn_q;
                        win_mask <= line_mask;
                    end else if (move_cnt == 4'd9) begin
                        st <= S_DRAW;
                    end else begin
                        turn_q <= ~turn_q;
                        st     <= S_PLAY;
                    end
                end
                S_WIN, S_DRAW: begin
                    if (btn_rise[4]) begin
                        occ      <= '0;
                        own      <= '0;
                        win_mask <= '0;
                        move_cnt <= '0;
                        cur_row  <= 2'd1;
                        cur_col  <= 2'd1;
                        turn_q   <= 1'b0;
                        st       <= S_PLAY;
                    end
                end
                default: st <= S_PLAY;
            endcase

            cells  <= cells_d;
            color  <= color_d;
            turn   <= turn_q;
            state  <= st;
            winner <= winner_q;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
//   Directed bench for game_controller. Expected output snapshots are pushed
//   to a scoreboard queue when each stimulus is driven and popped/compared
//   once the registered outputs reflect it. Outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_game_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right, btn_place;
    logic [17:0] cells;
    logic [8:0]  color;
    logic        turn;
    logic [1:0]  state;
    logic        winner;

    // Button masks, ordered {place, up, down, left, right}.
    localparam logic [4:0] B_PLACE = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    game_controller dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_place (btn_place),
        .cells     (cells),
        .color     (color),
        .turn      (turn),
        .state     (state),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] cells;
        logic [8:0]  color;
        logic        turn;
        logic [1:0]  state;
        logic        winner;
        logic        use_cells;
        logic        use_winner;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Reference model of the board, used for intermediate PLAY views.
    int    m_own[9];
    int    m_cur;
    logic  m_turn;

    task automatic check(input string tag, input string field,
                         input logic [17:0] obs, input logic [17:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [17:0] c, input logic [8:0] col,
                        input logic t, input logic [1:0] s, input logic w,
                        input logic use_c, input logic use_w);
        exp_t e;
        e.cells = c; e.color = col; e.turn = t; e.state = s; e.winner = w;
        e.use_cells = use_c; e.use_winner = use_w;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_next();
        exp_t  e;
        string tag;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e   = sb.pop_front();
        tag = tag_q.pop_front();
        if (e.use_cells) check(tag, "cells", cells, e.cells);
        check(tag, "color", 18'(color), 18'(e.color));
        check(tag, "turn",  18'(turn),  18'(e.turn));
        check(tag, "state", 18'(state), 18'(e.state));
        if (e.use_winner) check(tag, "winner", 18'(winner), 18'(e.winner));
    endtask

    // Expected PLAY-state outputs derived from the model board.
    task automatic push_model(input string tag);
        logic [17:0] c;
        logic [8:0]  col;
        c   = '0;
        col = '0;
        for (int k = 0; k < 9; k++) begin
            if (m_own[k] >= 0) begin
                c[2*k]   = 1'b1;
                c[2*k+1] = (m_own[k] == 1);
                col[k]   = (k == m_cur);
            end else if (k == m_cur) begin
                c[2*k]   = 1'b1;
                c[2*k+1] = m_turn;
                col[k]   = 1'b1;
            end
        end
        push(tag, c, col, m_turn, 2'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // Drive a one-cycle-plus pulse; returns once the outputs reflect it.
    task automatic press(input logic [4:0] b);
        @(negedge clk) set_btns(b);
        @(negedge clk) set_btns(5'b0);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_own[k] = -1;
        m_cur  = 4;
        m_turn = 1'b0;
    endtask

    task automatic move(input logic [4:0] b);
        int r, c;
        r = m_cur / 3;
        c = m_cur % 3;
        if (b == B_UP)    r = (r + 2) % 3;
        if (b == B_DOWN)  r = (r + 1) % 3;
        if (b == B_LEFT)  c = (c + 2) % 3;
        if (b == B_RIGHT) c = (c + 1) % 3;
        m_cur = r * 3 + c;
        press(b);
    endtask

    task automatic goto_cell(input int t);
        while (m_cur % 3 != t % 3) move(B_RIGHT);
        while (m_cur / 3 != t / 3) move(B_DOWN);
    endtask

    // Place at t and compare against the model once CHECK has resolved.
    task automatic place_at(input int t);
        goto_cell(t);
        m_own[t] = m_turn ? 1 : 0;
        m_turn   = ~m_turn;
        push_model($sformatf("place_%0d", t));
        press(B_PLACE);
        @(negedge clk);
        compare_next();
    endtask

    task automatic do_reset();
        @(negedge clk) begin
            reset = 1'b0;
            set_btns(5'b0);
        end
        @(negedge clk) reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        set_btns(B_RIGHT);             // held through reset release
        model_reset();

        // Outputs while reset is asserted.
        repeat (3) @(negedge clk);
        push("in_reset", 18'h0, 9'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        compare_next();

        // Release with right still held: no move, preview at cell 4.
        reset = 1'b1;
        push("reset_release", 18'h00100, 9'h010, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        compare_next();
        set_btns(5'b0);
        repeat (2) @(negedge clk);

        // Cursor moves and wrap-around.
        push("right_1", 18'h00400, 9'h020, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        move(B_RIGHT);
        compare_next();
        push("right_wrap", 18'h00040, 9'h008, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        move(B_RIGHT);
        compare_next();
        move(B_UP);                    // 3 -> 0
        move(B_RIGHT);                 // 0 -> 1
        push("up_wrap", 18'h04000, 9'h080, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        move(B_UP);                    // 1 -> 7
        compare_next();
        move(B_UP);                    // 7 -> 4

        // Place at 4: one CHECK cycle, then turn passes to player 1.
        push("place_check", 18'h00100, 9'h010, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        press(B_PLACE);
        compare_next();
        push("after_check", 18'h00100, 9'h010, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        compare_next();

        // Place on the occupied cell is ignored.
        push("place_occupied", 18'h00100, 9'h010, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        press(B_PLACE);
        compare_next();
        push("place_occupied_hold", 18'h00100, 9'h010, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        compare_next();

        // Top-row win for player 0.
        do_reset();
        place_at(0);
        place_at(3);
        place_at(1);
        place_at(4);
        goto_cell(2);
        push("win", 18'h0, 9'b000000111, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
        press(B_PLACE);
        @(negedge clk);
        compare_next();

        // Full board with no line, then restart.
        do_reset();
        place_at(0);
        place_at(1);
        place_at(2);
        place_at(4);
        place_at(3);
        place_at(5);
        place_at(7);
        place_at(6);
        goto_cell(8);
        push("draw", 18'h0, 9'h0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        press(B_PLACE);
        @(negedge clk);
        compare_next();
        push("restart", 18'h00100, 9'h010, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        press(B_PLACE);
        compare_next();

        // Place and up in the same cycle: place wins, cursor stays at 4.
        do_reset();
        push("place_vs_up", 18'h00100, 9'h010, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        press(B_PLACE | B_UP);
        compare_next();
        push("place_vs_up_done", 18'h00100, 9'h010, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        compare_next();

        // Reset pulsed while CHECK is pending discards the move.
        do_reset();
        @(negedge clk) set_btns(B_PLACE);
        @(negedge clk) begin
            reset = 1'b0;
            set_btns(5'b0);
        end
        #1;
        push("reset_mid_check", 18'h0, 9'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        compare_next();
        @(negedge clk) reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        push("after_mid_check_reset", 18'h00100, 9'h010, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        compare_next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
